// File: rtl/packet_checker.sv
// packet_checker: passive receive-side checker for an AXI-Stream Ethernet frame.
// Checks each frame's header, filler uniformity, tkeep legality and length, then
// reports per-frame results and keeps running statistics.
module packet_checker #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 1518
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic [47:0]             exp_d_mac,
  input  logic [47:0]             exp_s_mac,
  input  logic [15:0]             exp_ethertype,
  input  logic                    hdr_check_en,
  input  logic                    clear_stats,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic [15:0]             frame_len,
  output logic [3:0]              frame_flags,
  output logic [31:0]             frame_count,
  output logic [31:0]             err_count,
  output logic [3:0]              sticky_flags
);

  localparam int unsigned KW    = DATA_WIDTH / 8;
  localparam int unsigned PW    = $clog2(KW + 1);
  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  typedef enum logic {SOF, BODY} state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [2:0]  acc_flags_q, acc_flags_d;
  logic [7:0]  fill_q, fill_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] flen_q, flen_d;
  logic [3:0]  fflags_q, fflags_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] errc_q, errc_d;
  logic [3:0]  sticky_q, sticky_d;

  logic          first;
  logic [7:0]    fill_ref;
  logic          hdr_err;
  logic          fill_err;
  logic          keep_err;
  logic          len_err;
  logic [PW-1:0] pop;
  logic [KW-1:0] keep_inc;
  logic [16:0]   len_sum;
  logic [15:0]   len_new;
  logic [3:0]    flags_new;

  // Per-beat evaluation: checks on the current beat merged with the frame so far
  always_comb begin
    first    = (state_q == SOF);
    fill_ref = first ? s_axis_tdata[119:112] : fill_q;
    hdr_err  = first && hdr_check_en &&
               ((s_axis_tdata[47:0]   != exp_d_mac) ||
                (s_axis_tdata[95:48]  != exp_s_mac) ||
                (s_axis_tdata[111:96] != exp_ethertype));
    fill_err = 1'b0;
    pop      = '0;
    for (int k = 0; k < KW; k++) begin
      pop = pop + PW'(s_axis_tkeep[k]);
      // Only the first beat holds header bytes; every later byte index is >= 14
      if (s_axis_tkeep[k] && (!first || k >= 14) && (s_axis_tdata[8*k +: 8] != fill_ref)) begin
        fill_err = 1'b1;
      end
    end
    keep_inc = s_axis_tkeep + KW'(1);
    if (s_axis_tlast) begin
      keep_err = (s_axis_tkeep == '0) || ((s_axis_tkeep & keep_inc) != '0);
    end else begin
      keep_err = (s_axis_tkeep != '1);
    end
    len_sum   = {1'b0, (first ? 16'd0 : len_q)} + 17'(pop);
    len_new   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    len_err   = (len_new < MIN_L) || (len_new > MAX_L);
    flags_new = {len_err, (first ? 3'b000 : acc_flags_q) | {keep_err, fill_err, hdr_err}};
  end

  // Next state, frame accumulation and completion reporting
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_flags_d = acc_flags_q;
    fill_d      = fill_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    flen_d      = flen_q;
    fflags_d    = fflags_q;
    cnt_d       = clear_stats ? 32'd0 : cnt_q;
    errc_d      = clear_stats ? 32'd0 : errc_q;
    sticky_d    = clear_stats ? 4'd0  : sticky_q;
    if (s_axis_tvalid) begin
      fill_d      = fill_ref;
      len_d       = len_new;
      acc_flags_d = flags_new[2:0];
      if (s_axis_tlast) begin
        state_d     = SOF;
        len_d       = 16'd0;
        acc_flags_d = 3'b000;
        fill_d      = 8'd0;
        done_d      = 1'b1;
        err_d       = |flags_new;
        flen_d      = len_new;
        fflags_d    = flags_new;
        cnt_d       = cnt_d + 32'd1;
        errc_d      = errc_d + 32'(|flags_new);
        sticky_d    = sticky_d | flags_new;
      end else begin
        state_d = BODY;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SOF;
      len_q       <= '0;
      acc_flags_q <= '0;
      fill_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      flen_q      <= '0;
      fflags_q    <= '0;
      cnt_q       <= '0;
      errc_q      <= '0;
      sticky_q    <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_flags_q <= acc_flags_d;
      fill_q      <= fill_d;
      done_q      <= done_d;
      err_q       <= err_d;
      flen_q      <= flen_d;
      fflags_q    <= fflags_d;
      cnt_q       <= cnt_d;
      errc_q      <= errc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign frame_done   = done_q;
  assign frame_err    = err_q;
  assign frame_len    = flen_q;
  assign frame_flags  = fflags_q;
  assign frame_count  = cnt_q;
  assign err_count    = errc_q;
  assign sticky_flags = sticky_q;

endmodule

// File: doc/packet_checker.md
# packet_checker

Receive-side checker placed directly downstream of the Ethernet frame generator's AXI-Stream output. It checks each frame's header fields, filler uniformity, tkeep legality and length. It reports per-frame results and accumulates statistics for the test harness. It is passive: the stream has no back-pressure, so the checker accepts every beat on which tvalid is high.

## Interface
- DATA_WIDTH, 512, stream width in bits; legal values are multiples of 128 from 128 upward.
- MIN_LEN, 60, minimum legal frame length in bytes.
- MAX_LEN, 1518, maximum legal frame length in bytes.

- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  stream data; byte k is tdata[8k+7:8k].
- s_axis_tkeep  in  DATA_WIDTH/8  byte enables.
- s_axis_tvalid  in  1  beat valid; every valid beat is consumed.
- s_axis_tlast  in  1  last beat of frame.
- exp_d_mac  in  48  expected tdata[47:0] of the first beat.
- exp_s_mac  in  48  expected tdata[95:48] of the first beat.
- exp_ethertype  in  16  expected tdata[111:96] of the first beat.
- hdr_check_en  in  1  enables the header compare; sampled on the first beat.
- clear_stats  in  1  synchronous clear of the counters and sticky flags.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_err  out  1  one-cycle pulse, coincident with frame_done, when frame_flags is non-zero.
- frame_len  out  16  byte length of the last completed frame.
- frame_flags  out  4  error flags of the last completed frame: [0] HDR, [1] FILL, [2] KEEP, [3] LEN.
- frame_count  out  32  completed frames.
- err_count  out  32  completed frames with any flag set.
- sticky_flags  out  4  OR of frame_flags since reset or clear.

## Operation
- FSM has two states.
  - SOF: waiting for the first beat.
  - BODY: inside a frame.
- Reset state is SOF. All outputs and internal registers reset to 0.
- Beat handling:
  - A beat is a cycle with tvalid=1. Cycles with tvalid=0 are ignored in both states; there is no timeout.
  - A beat in SOF is a first beat. If tlast=0 the FSM moves to BODY; if tlast=1 it stays in SOF.
  - A beat in BODY with tlast=1 returns the FSM to SOF.
- First-beat checks:
  - Capture the filler reference F = byte 14.
  - HDR is set if hdr_check_en=1 and any of the three header fields differs from its expected value.
- Filler check: on every beat, each kept byte whose in-frame index is ≥14 must equal F; any mismatch sets FILL.
- tkeep rules:
  - A non-last beat must have tkeep all-ones.
  - A last beat must have non-zero tkeep that is contiguous from bit 0 (1s then 0s).
  - A violation sets KEEP.
- Length:
  - Accumulated as the popcount of tkeep per beat, into a 16-bit accumulator that saturates at 65535.
  - LEN is set if the final length is < MIN_LEN or > MAX_LEN.
- Frame completion, on the tlast beat:
  - Latch frame_len and frame_flags.
  - Increment frame_count, and increment err_count if any flag is set. Both counters wrap modulo 2^32.
  - OR the flags into sticky_flags.
  - Clear the per-frame accumulators so a back-to-back next beat starts cleanly.
- clear_stats:
  - Zeroes frame_count, err_count and sticky_flags.
  - If it coincides with a completion, the completing frame is applied after the clear: counts become 1/0 or 1/1 and sticky_flags becomes that frame's flags.
  - frame_len and frame_flags are unaffected.

## Timing
- frame_done, frame_err, frame_len, frame_flags and the counters update on the clock edge after the tlast beat (1-cycle latency).
- frame_len and frame_flags hold until the next completion.
- Back-to-back frames (a tlast beat followed by a first beat on the next cycle) are supported at full rate. Consecutive single-beat frames give frame_done high on consecutive cycles.
- Reset asserted mid-frame returns the FSM to SOF immediately and discards the partial frame; no frame_done is produced for it.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Scenarios use DATA_WIDTH=512 and hdr_check_en=1.
- Good multi-beat frame: header matches, filler 0xA5, beats keep=all-ones, all-ones, lower 22 bits -> one cycle after the last beat frame_done=1, frame_len=150, frame_flags=0, frame_count=1.
- Header mismatch: exp_ethertype=0x0800, frame carries 0x86DD -> flags=0001, err_count=1. Repeat with hdr_check_en=0 -> flags=0000.
- Filler and keep errors: byte 70 = 0x00 with filler 0xA5 -> FILL. A middle beat with keep=0x7FFF...F -> KEEP. A last beat with keep=0x5 -> KEEP.
- Length bounds: single beat with keep lower 40 bits -> LEN (len 40). A 24-beat all-ones frame -> LEN (len 1536). A 64-byte single full beat -> no LEN.
- Back-to-back: three single-beat frames on consecutive cycles with a tvalid gap inside a fourth frame -> frame_done on three consecutive cycles, then one more pulse; frame_count=4.
- Reset and clear: assert rst mid-frame -> no frame_done, all counters 0. clear_stats coincident with an erroneous frame's completion -> frame_count=1, err_count=1, sticky_flags equal to that frame's flags.
